// File: rtl/bpu_pkg.sv
// Branch prediction unit shared types.
// Counter encoding and saturating helpers.
package bpu_pkg;

    typedef logic [1:0] bhtctr_t;

    localparam bhtctr_t STRONG_NT = 2'b00;
    localparam bhtctr_t WEAK_NT   = 2'b01;
    localparam bhtctr_t WEAK_T    = 2'b10;
    localparam bhtctr_t STRONG_T  = 2'b11;

    function automatic bhtctr_t ctr_inc(input bhtctr_t c);
        return (c == STRONG_T) ? c : c + 2'd1;
    endfunction

    function automatic bhtctr_t ctr_dec(input bhtctr_t c);
        return (c == STRONG_NT) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/bpu.sv
// Branch prediction unit: direct-mapped BTB with 2-bit counters,
// combinational fetch lookup, registered update, execute mispredict.
module bpu
    import bpu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BTB_ENTRIES = 64,
    localparam int IDX_W      = $clog2(BTB_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc_f,
    output logic                  pred_taken_f,
    output logic [DATA_WIDTH-1:0] pred_target_f,
    input  logic                  ex_valid,
    input  logic [DATA_WIDTH-1:0] ex_pc,
    input  logic                  ex_is_jump,
    input  logic                  ex_taken,
    input  logic [DATA_WIDTH-1:0] ex_target,
    input  logic                  ex_pred_taken,
    input  logic [DATA_WIDTH-1:0] ex_pred_target,
    output logic                  mispredict,
    output logic [DATA_WIDTH-1:0] redirect_pc
);

    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    // Valid bits live apart from the entry so reset clears them at once.
    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [DATA_WIDTH-1:0] target;
        bhtctr_t               ctr;
    } btb_entry_t;

    logic [BTB_ENTRIES-1:0] valid_q;
    btb_entry_t             btb_q [BTB_ENTRIES];

    logic [IDX_W-1:0]      f_idx;
    logic [TAG_W-1:0]      f_tag;
    btb_entry_t            f_ent;
    logic                  f_hit;

    logic [IDX_W-1:0]      e_idx;
    logic [TAG_W-1:0]      e_tag;
    btb_entry_t            e_ent;
    logic                  e_hit;
    logic [DATA_WIDTH-1:0] actual_next;

    logic                  upd_en;
    btb_entry_t            upd_ent;

    assign f_idx = pc_f[IDX_W+1:2];
    assign f_tag = pc_f[DATA_WIDTH-1:IDX_W+2];
    assign f_ent = btb_q[f_idx];
    assign f_hit = valid_q[f_idx] && (f_ent.tag == f_tag);

    assign pred_taken_f  = ~rst & f_hit & f_ent.ctr[1];
    assign pred_target_f = pred_taken_f ? f_ent.target
                                        : pc_f + DATA_WIDTH'(4);

    assign e_idx = ex_pc[IDX_W+1:2];
    assign e_tag = ex_pc[DATA_WIDTH-1:IDX_W+2];
    assign e_ent = btb_q[e_idx];
    assign e_hit = valid_q[e_idx] && (e_ent.tag == e_tag);

    assign actual_next = ex_taken ? ex_target : ex_pc + DATA_WIDTH'(4);

    // Flush when direction or taken target disagrees with fetch.
    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = '0;
        if (!rst && ex_valid) begin
            mispredict = (ex_pred_taken != ex_taken) ||
                         (ex_taken && (ex_pred_target != ex_target));
            if (mispredict) begin
                redirect_pc = actual_next;
            end
        end
    end

    // Compute the entry to write back for the resolving instruction.
    always_comb begin
        upd_en  = 1'b0;
        upd_ent = e_ent;
        if (ex_valid) begin
            if (e_hit) begin
                upd_en = 1'b1;
                if (ex_taken) begin
                    upd_ent.ctr    = ctr_inc(e_ent.ctr);
                    upd_ent.target = ex_target;
                end else begin
                    upd_ent.ctr = ctr_dec(e_ent.ctr);
                end
                if (ex_is_jump) begin
                    upd_ent.ctr = STRONG_T;
                end
            end else if (ex_taken) begin
                upd_en         = 1'b1;
                upd_ent.tag    = e_tag;
                upd_ent.target = ex_target;
                upd_ent.ctr    = ex_is_jump ? STRONG_T : WEAK_T;
            end
        end
    end

    // Table write; reset invalidates everything and drops the update.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (upd_en) begin
            valid_q[e_idx] <= 1'b1;
            btb_q[e_idx]   <= upd_ent;
        end
    end

endmodule

// File: tb/tb_bpu.sv
// Testbench for bpu: directed scenarios with literal expectations
// plus randomized traffic checked against a behavioural table model.
module tb_bpu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_jump;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    int vectors = 0;
    int errors  = 0;

    bit          m_valid [64];
    logic [31:0] m_pc    [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];

    bpu #(.DATA_WIDTH(32), .BTB_ENTRIES(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_f           (pc_f),
        .pred_taken_f   (pred_taken_f),
        .pred_target_f  (pred_target_f),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_jump     (ex_is_jump),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic int ix(input logic [31:0] p);
        return int'((p >> 2) % 32'd64);
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_check();
        int          i;
        bit          hit;
        bit          pt;
        bit          mis;
        logic [31:0] ptgt;
        logic [31:0] redir;
        i    = ix(pc_f);
        hit  = m_valid[i] && ((m_pc[i] >> 8) == (pc_f >> 8));
        pt   = !rst && hit && (m_ctr[i] >= 2);
        ptgt = pt ? m_tgt[i] : pc_f + 32'd4;
        mis  = !rst && ex_valid &&
               ((ex_pred_taken != ex_taken) ||
                (ex_taken && ex_pred_target != ex_target));
        redir = !mis ? 32'd0 : (ex_taken ? ex_target : ex_pc + 32'd4);
        chk("m_pred_taken", {31'd0, pred_taken_f}, {31'd0, pt});
        chk("m_pred_target", pred_target_f, ptgt);
        chk("m_mispredict", {31'd0, mispredict}, {31'd0, mis});
        chk("m_redirect", redirect_pc, redir);
    endtask

    task automatic model_update();
        int i;
        bit hit;
        if (rst) begin
            for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
        end else if (ex_valid) begin
            i   = ix(ex_pc);
            hit = m_valid[i] && ((m_pc[i] >> 8) == (ex_pc >> 8));
            if (hit) begin
                if (ex_taken) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = ex_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
                if (ex_is_jump) m_ctr[i] = 3;
            end else if (ex_taken) begin
                m_valid[i] = 1'b1;
                m_pc[i]    = ex_pc;
                m_tgt[i]   = ex_target;
                m_ctr[i]   = ex_is_jump ? 3 : 2;
            end
        end
    endtask

    task automatic eval();
        #1;
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic setex(input logic v, input logic [31:0] p,
                         input logic j, input logic t,
                         input logic [31:0] tg, input logic pt,
                         input logic [31:0] ptg);
        ex_valid       = v;
        ex_pc          = p;
        ex_is_jump     = j;
        ex_taken       = t;
        ex_target      = tg;
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
    endtask

    initial begin
        logic [31:0] rp;
        rst  = 1'b1;
        pc_f = 32'h100;
        setex(1'b1, 32'h40, 1'b0, 1'b1, 32'h999, 1'b0, 32'h44);
        @(negedge clk);
        eval();
        chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("rst_pred_taken", {31'd0, pred_taken_f}, 32'd0);
        adv();

        rst = 1'b0;
        ex_valid = 1'b0;
        eval();
        chk("cold_pred", {31'd0, pred_taken_f}, 32'd0);
        chk("cold_target", pred_target_f, 32'h104);

        setex(1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        eval();
        chk("alloc_mis", {31'd0, mispredict}, 32'd1);
        chk("alloc_redir", redirect_pc, 32'h80);
        chk("alloc_same_cycle", {31'd0, pred_taken_f}, 32'd0);
        adv();
        ex_valid = 1'b0;
        eval();
        chk("alloc_pred", {31'd0, pred_taken_f}, 32'd1);
        chk("alloc_target", pred_target_f, 32'h80);

        repeat (3) begin
            setex(1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
            eval();
            chk("sat_no_mis", {31'd0, mispredict}, 32'd0);
            adv();
        end
        repeat (2) begin
            setex(1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
            eval();
            chk("nt_redir", redirect_pc, 32'h104);
            adv();
        end
        ex_valid = 1'b0;
        eval();
        chk("sat_weak_nt", {31'd0, pred_taken_f}, 32'd0);
        chk("sat_target", pred_target_f, 32'h104);

        setex(1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
        eval();
        adv();
        setex(1'b1, 32'h200, 1'b0, 1'b1, 32'h300, 1'b0, 32'h204);
        eval();
        adv();
        ex_valid = 1'b0;
        pc_f = 32'h100;
        eval();
        chk("alias_old", {31'd0, pred_taken_f}, 32'd0);
        pc_f = 32'h200;
        eval();
        chk("alias_new", {31'd0, pred_taken_f}, 32'd1);
        chk("alias_target", pred_target_f, 32'h300);

        setex(1'b1, 32'h500, 1'b0, 1'b1, 32'h90, 1'b1, 32'h80);
        eval();
        chk("tgt_mis", {31'd0, mispredict}, 32'd1);
        chk("tgt_redir", redirect_pc, 32'h90);
        adv();
        setex(1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
        eval();
        chk("nt_nt_mis", {31'd0, mispredict}, 32'd0);
        chk("nt_nt_redir", redirect_pc, 32'd0);
        adv();

        pc_f = 32'h40;
        setex(1'b1, 32'h40, 1'b1, 1'b1, 32'h1000, 1'b0, 32'h44);
        eval();
        chk("same_cycle_old", {31'd0, pred_taken_f}, 32'd0);
        adv();
        ex_valid = 1'b0;
        eval();
        chk("same_cycle_new", {31'd0, pred_taken_f}, 32'd1);
        chk("jal_target", pred_target_f, 32'h1000);
        setex(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1000);
        eval();
        adv();
        ex_valid = 1'b0;
        eval();
        chk("jal_strong", {31'd0, pred_taken_f}, 32'd1);

        pc_f = 32'hFFFF_FFFC;
        eval();
        chk("wrap_pred", {31'd0, pred_taken_f}, 32'd0);
        chk("wrap_target", pred_target_f, 32'h0);

        rst  = 1'b1;
        pc_f = 32'h40;
        setex(1'b1, 32'h40, 1'b1, 1'b1, 32'h2000, 1'b0, 32'h44);
        eval();
        chk("midrst_mis", {31'd0, mispredict}, 32'd0);
        chk("midrst_pred", {31'd0, pred_taken_f}, 32'd0);
        adv();
        rst = 1'b0;
        ex_valid = 1'b0;
        eval();
        chk("midrst_inval40", {31'd0, pred_taken_f}, 32'd0);
        pc_f = 32'h200;
        eval();
        chk("midrst_inval200", {31'd0, pred_taken_f}, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            rp  = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 8)
                | $urandom_range(0, 3);
            pc_f = ($urandom_range(0, 9) == 0) ? $urandom : rp;
            rp  = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 8)
                | $urandom_range(0, 3);
            setex($urandom_range(0, 3) != 0, rp,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                  32'h1000 + ($urandom_range(0, 3) << 4),
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 1) == 1) ? rp + 32'd4
                      : 32'h1000 + ($urandom_range(0, 3) << 4));
            if (ex_is_jump) ex_taken = 1'b1;
            eval();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
